match_event_logger: RTL and testbench

MATCH_EVENT_LOGGER -- requirements
Module: match_event_logger

---
 rtl/match_event_logger_pkg.sv | 15 +
 rtl/match_event_logger_if.sv | 15 +
 rtl/match_event_logger_fifo.sv | 59 +++++
 rtl/match_event_logger.sv | 73 +++++++
 tb/tb_match_event_logger.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/match_event_logger_pkg.sv
// Shared defaults and width helpers for the match event logger slice.
package match_log_pkg;

  localparam int TS_W_DEFAULT  = 16;
  localparam int DEPTH_DEFAULT = 4;
  localparam int CNT_W_DEFAULT = 8;

  // Occupancy needs one extra bit so that "full" (== DEPTH) is representable.
  function automatic int lvl_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int LVL_W = lvl_width(DEPTH_DEFAULT);

endpackage

// File: rtl/match_event_logger_if.sv
// Valid/ready stream carrying logged match timestamps out of the logger.
interface match_event_logger_if
  import match_log_pkg::*;
#(
  parameter int TS_W = TS_W_DEFAULT
);

  logic            out_valid;
  logic            out_ready;
  logic [TS_W-1:0] out_ts;

  modport master (output out_valid, output out_ts, input out_ready);
  modport slave  (input out_valid, input out_ts, output out_ready);

endinterface

// File: rtl/match_event_logger_fifo.sv
// Timestamp FIFO: storage, wrapping pointers and registered occupancy/valid.
module match_log_fifo
  import match_log_pkg::*;
#(
  parameter  int W     = TS_W_DEFAULT,
  parameter  int DEPTH = DEPTH_DEFAULT,
  localparam int LW    = lvl_width(DEPTH),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic          valid,
  output logic [W-1:0]  head,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level_nxt;

  always_comb begin
    level_nxt = level;
    if (push && !pop) begin
      level_nxt = level + LW'(1);
    end else if (!push && pop) begin
      level_nxt = level - LW'(1);
    end
  end

  // DEPTH is a power of two, so pointer overflow is exactly the modulo wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      valid  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      level <= level_nxt;
      valid <= (level_nxt != '0);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/match_event_logger.sv
// Timestamps upstream match pulses into a FIFO, counts matches, flags drops.
module match_event_logger
  import match_log_pkg::*;
#(
  parameter  int TS_W  = TS_W_DEFAULT,
  parameter  int DEPTH = DEPTH_DEFAULT,
  parameter  int CNT_W = CNT_W_DEFAULT,
  localparam int LW    = lvl_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  match_in,
  input  logic                  clr_ovf,
  match_event_logger_if.master  bus,
  output logic [LW-1:0]         level,
  output logic [CNT_W-1:0]      match_count,
  output logic                  overflow
);

  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] fifo_head;
  logic            fifo_valid;
  logic            capture;
  logic            pop;
  logic            push;
  logic            drop;

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign capture = en & match_in;
  assign pop     = fifo_valid & bus.out_ready;
  assign push    = capture & ((level != LW'(DEPTH)) | pop);
  assign drop    = capture & ~push;

  match_log_fifo #(
    .W     (TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (ts_cnt),
    .pop       (pop),
    .valid     (fifo_valid),
    .head      (fifo_head),
    .level     (level)
  );

  assign bus.out_valid = fifo_valid;
  assign bus.out_ts    = fifo_head;

  // A drop on the same edge as a clear leaves the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt      <= '0;
      match_count <= '0;
      overflow    <= 1'b0;
    end else begin
      if (en) begin
        ts_cnt <= ts_cnt + TS_W'(1);
      end
      if (capture && (match_count != '1)) begin
        match_count <= match_count + CNT_W'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_match_event_logger.sv
// Self-checking bench: directed scenarios plus random traffic against a queue model.
module tb_match_event_logger;

  localparam int TS_W  = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             match_in;
  logic             clr_ovf;
  logic [LW-1:0]    level;
  logic [CNT_W-1:0] match_count;
  logic             overflow;

  int checks   = 0;
  int failures = 0;

  int q[$];
  int m_ts;
  int m_cnt;
  bit m_ovf;
  int exp_drain[4] = '{2, 4, 6, 8};

  always #5 clk = ~clk;

  match_event_logger_if #(.TS_W(TS_W)) bus ();

  match_event_logger #(
    .TS_W  (TS_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .match_in    (match_in),
    .clr_ovf     (clr_ovf),
    .bus         (bus),
    .level       (level),
    .match_count (match_count),
    .overflow    (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    q.delete();
    m_ts  = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  task automatic checkOutput();
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() != 0});
    chk("level", {29'd0, level}, q.size());
    if (q.size() != 0) chk("out_ts", {28'd0, bus.out_ts}, q[0]);
    chk("match_count", {24'd0, match_count}, m_cnt);
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
  endtask

  // One clock edge: drive inputs, let the model apply the logger's rules, compare.
  task automatic applyStimulus(input bit e, input bit m, input bit c, input bit r);
    bit pop;
    bit cap;
    bit room;
    en            = e;
    match_in      = m;
    clr_ovf       = c;
    bus.out_ready = r;
    @(posedge clk);
    pop  = (q.size() != 0) && r;
    cap  = e && m;
    room = (q.size() < DEPTH) || pop;
    if (pop) void'(q.pop_front());
    if (cap && room) q.push_back(m_ts);
    if (cap && !room) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    if (cap && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    if (e) m_ts = (m_ts + 1) % (1 << TS_W);
    #1;
    checkOutput();
  endtask

  task automatic resetDut();
    rst           = 1'b1;
    en            = 1'b0;
    match_in      = 1'b0;
    clr_ovf       = 1'b0;
    bus.out_ready = 1'b0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    resetDut();
    chk("rst_ts", {28'd0, bus.out_ts}, 0);
    checkOutput();

    // Single match at ts 5, then one pop.
    while (m_ts != 5) applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0);
    chk("single_ts", {28'd0, bus.out_ts}, 5);
    chk("single_level", {29'd0, level}, 1);
    applyStimulus(1, 0, 0, 1);
    chk("single_pop_level", {29'd0, level}, 0);

    // Overflow: five matches into a four-entry FIFO, then drain in order.
    resetDut();
    for (int i = 0; i < 11; i++) applyStimulus(1, (m_ts % 2 == 0) && m_ts >= 2, 0, 0);
    chk("ovf_level", {29'd0, level}, 4);
    chk("ovf_flag", {31'd0, overflow}, 1);
    chk("ovf_count", {24'd0, match_count}, 5);
    for (int i = 0; i < 4; i++) begin
      chk("drain_ts", {28'd0, bus.out_ts}, exp_drain[i]);
      applyStimulus(0, 0, 0, 1);
    end
    chk("drain_empty", {31'd0, bus.out_valid}, 0);

    // Full with simultaneous pop and push: ts 11..14 stored, 15 pushed.
    applyStimulus(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 1);
    chk("fullpp_level", {29'd0, level}, 4);
    chk("fullpp_ovf", {31'd0, overflow}, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1);
    chk("fullpp_new_ts", {28'd0, bus.out_ts}, 15);
    applyStimulus(0, 0, 0, 1);

    // Clear and drop on the same edge: set wins.
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 1, 0);
    chk("clr_vs_drop", {31'd0, overflow}, 1);
    applyStimulus(0, 0, 1, 0);
    chk("clr_only", {31'd0, overflow}, 0);

    // Timestamp wrap: matches at 15 and 0.
    resetDut();
    while (m_ts != 15) applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    chk("wrap_first", {28'd0, bus.out_ts}, 15);
    applyStimulus(0, 0, 0, 1);
    chk("wrap_second", {28'd0, bus.out_ts}, 0);

    // Counter saturation, then en=0 must freeze counter and timestamp.
    resetDut();
    for (int i = 0; i < 300; i++) applyStimulus(1, 1, 0, 1);
    chk("sat_count", {24'd0, match_count}, 255);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 1);
    chk("en0_count", {24'd0, match_count}, 255);
    applyStimulus(1, 1, 0, 0);
    chk("en0_ts_frozen", {28'd0, bus.out_ts}, 300 % 16);

    // Asynchronous reset mid-cycle with level 3 and overflow set.
    resetDut();
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 0, 0, 1);
    chk("pre_rst_level", {29'd0, level}, 3);
    chk("pre_rst_ovf", {31'd0, overflow}, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_valid", {31'd0, bus.out_valid}, 0);
    chk("async_level", {29'd0, level}, 0);
    chk("async_count", {24'd0, match_count}, 0);
    chk("async_ovf", {31'd0, overflow}, 0);
    chk("async_ts", {28'd0, bus.out_ts}, 0);
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1, 1, 0, 0);
    chk("cold_ts", {28'd0, bus.out_ts}, 0);

    // Random traffic against the model.
    resetDut();
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1,
                    $urandom_range(9, 0) == 0, $urandom_range(1, 0) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
